alu_bist_sequencer: RTL and testbench

Hardware self-test initiator for the 32-bit ALU; drives operandA, operandB and command and checks result, carryout, zero and overflow against an internal golden model.
Operand pairs come from two 32-bit LFSRs, and every pair is applied with all 8 commands.
Reports busy, done, pass, a saturating error count and the first failing check.
Sits beside the ALU in the lab top level; the ALU stays purely combinational.

---
 rtl/alu_bist_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_alu_bist_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bist_sequencer.sv
// Self-test initiator for the 32-bit combinational ALU: drives LFSR operand pairs through all
// eight commands, checks the ALU against a built-in golden model and reports the outcome.
module alu_bist_sequencer #(
    parameter int          NUM_VECTORS   = 16,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [31:0] SEED_A        = 32'h0000_0004,
    parameter logic [31:0] SEED_B        = 32'hFFFF_FFFE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [2:0]  alu_command,
    input  logic [31:0] alu_result,
    input  logic        alu_carryout,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] error_count,
    output logic [18:0] first_fail_index,
    output logic [2:0]  first_fail_command
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [31:0] SEED_A_INIT = (SEED_A == 32'd0) ? 32'd1 : SEED_A;
    localparam logic [31:0] SEED_B_INIT = (SEED_B == 32'd0) ? 32'd1 : SEED_B;
    localparam logic [31:0] LFSR_TAPS   = 32'h0040_0007;
    localparam logic [15:0] LAST_VECTOR = 16'(NUM_VECTORS - 1);
    localparam logic [7:0]  LAST_SETTLE = 8'(SETTLE_CYCLES - 1);

    localparam logic [2:0] CMD_ADD  = 3'd0;
    localparam logic [2:0] CMD_SUB  = 3'd1;
    localparam logic [2:0] CMD_XOR  = 3'd2;
    localparam logic [2:0] CMD_SLT  = 3'd3;
    localparam logic [2:0] CMD_AND  = 3'd4;
    localparam logic [2:0] CMD_NAND = 3'd5;
    localparam logic [2:0] CMD_NOR  = 3'd6;
    localparam logic [2:0] CMD_OR   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Galois step for x^32+x^22+x^2+x+1: multiply by x, reduce when x^32 appears.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? LFSR_TAPS : 32'd0);
    endfunction

    state_t      state_q, state_d;
    logic [31:0] operand_a_q, operand_a_d;
    logic [31:0] operand_b_q, operand_b_d;
    logic [2:0]  command_q, command_d;
    logic [31:0] lfsr_a_q, lfsr_a_d;
    logic [31:0] lfsr_b_q, lfsr_b_d;
    logic [15:0] vec_idx_q, vec_idx_d;
    logic [7:0]  settle_cnt_q, settle_cnt_d;
    logic [15:0] error_count_q, error_count_d;
    logic [18:0] first_fail_index_q, first_fail_index_d;
    logic [2:0]  first_fail_command_q, first_fail_command_d;

    logic [32:0] sum_ext;
    logic [32:0] diff_ext;
    logic [31:0] exp_result;
    logic        exp_carry;
    logic        exp_overflow;
    logic        exp_zero;
    logic        check_fail;
    logic [31:0] lfsr_a_adv;
    logic [31:0] lfsr_b_adv;

    always_comb begin
        sum_ext      = {1'b0, operand_a_q} + {1'b0, operand_b_q};
        diff_ext     = {1'b0, operand_a_q} + {1'b0, ~operand_b_q} + 33'd1;
        exp_result   = 32'd0;
        exp_carry    = 1'b0;
        exp_overflow = 1'b0;
        case (command_q)
            CMD_ADD: begin
                exp_result   = sum_ext[31:0];
                exp_carry    = sum_ext[32];
                exp_overflow = (operand_a_q[31] == operand_b_q[31]) &&
                               (sum_ext[31] != operand_a_q[31]);
            end
            CMD_SUB: begin
                exp_result   = diff_ext[31:0];
                exp_carry    = diff_ext[32];
                exp_overflow = (operand_a_q[31] != operand_b_q[31]) &&
                               (diff_ext[31] != operand_a_q[31]);
            end
            CMD_XOR:  exp_result = operand_a_q ^ operand_b_q;
            CMD_SLT:  exp_result = {31'd0, $signed(operand_a_q) < $signed(operand_b_q)};
            CMD_AND:  exp_result = operand_a_q & operand_b_q;
            CMD_NAND: exp_result = ~(operand_a_q & operand_b_q);
            CMD_NOR:  exp_result = ~(operand_a_q | operand_b_q);
            CMD_OR:   exp_result = operand_a_q | operand_b_q;
            default:  exp_result = 32'd0;
        endcase
        exp_zero   = (exp_result == 32'd0);
        check_fail = (alu_result != exp_result) || (alu_zero != exp_zero);
        // Carry and overflow only carry meaning for the arithmetic commands.
        if ((command_q == CMD_ADD) || (command_q == CMD_SUB)) begin
            check_fail = check_fail || (alu_carryout != exp_carry) ||
                         (alu_overflow != exp_overflow);
        end
    end

    always_comb begin
        state_d              = state_q;
        operand_a_d          = operand_a_q;
        operand_b_d          = operand_b_q;
        command_d            = command_q;
        lfsr_a_d             = lfsr_a_q;
        lfsr_b_d             = lfsr_b_q;
        vec_idx_d            = vec_idx_q;
        settle_cnt_d         = settle_cnt_q;
        error_count_d        = error_count_q;
        first_fail_index_d   = first_fail_index_q;
        first_fail_command_d = first_fail_command_q;
        lfsr_a_adv           = lfsr_step(lfsr_a_q);
        lfsr_b_adv           = lfsr_step(lfsr_b_q);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // A rerun from DONE restarts the operand sequence from the seeds.
                    if (state_q == ST_DONE) begin
                        lfsr_a_d    = SEED_A_INIT;
                        lfsr_b_d    = SEED_B_INIT;
                        operand_a_d = SEED_A_INIT;
                        operand_b_d = SEED_B_INIT;
                    end else begin
                        operand_a_d = lfsr_a_q;
                        operand_b_d = lfsr_b_q;
                    end
                    command_d            = CMD_ADD;
                    vec_idx_d            = 16'd0;
                    settle_cnt_d         = 8'd0;
                    error_count_d        = 16'd0;
                    first_fail_index_d   = 19'd0;
                    first_fail_command_d = 3'd0;
                    state_d              = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == LAST_SETTLE) begin
                    settle_cnt_d = 8'd0;
                    state_d      = ST_CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end
            ST_CHECK: begin
                if (check_fail) begin
                    // The count saturates and never returns to zero, so zero means no failure yet.
                    if (error_count_q == 16'd0) begin
                        first_fail_index_d   = {vec_idx_q, command_q};
                        first_fail_command_d = command_q;
                    end
                    if (error_count_q != 16'hFFFF) begin
                        error_count_d = error_count_q + 16'd1;
                    end
                end
                if (command_q == CMD_OR) begin
                    if (vec_idx_q == LAST_VECTOR) begin
                        state_d = ST_DONE;
                    end else begin
                        lfsr_a_d    = lfsr_a_adv;
                        lfsr_b_d    = lfsr_b_adv;
                        operand_a_d = lfsr_a_adv;
                        operand_b_d = lfsr_b_adv;
                        vec_idx_d   = vec_idx_q + 16'd1;
                        command_d   = CMD_ADD;
                        state_d     = ST_SETTLE;
                    end
                end else begin
                    command_d = command_q + 3'd1;
                    state_d   = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q              <= ST_IDLE;
            operand_a_q          <= 32'd0;
            operand_b_q          <= 32'd0;
            command_q            <= 3'd0;
            lfsr_a_q             <= SEED_A_INIT;
            lfsr_b_q             <= SEED_B_INIT;
            vec_idx_q            <= 16'd0;
            settle_cnt_q         <= 8'd0;
            error_count_q        <= 16'd0;
            first_fail_index_q   <= 19'd0;
            first_fail_command_q <= 3'd0;
        end else begin
            state_q              <= state_d;
            operand_a_q          <= operand_a_d;
            operand_b_q          <= operand_b_d;
            command_q            <= command_d;
            lfsr_a_q             <= lfsr_a_d;
            lfsr_b_q             <= lfsr_b_d;
            vec_idx_q            <= vec_idx_d;
            settle_cnt_q         <= settle_cnt_d;
            error_count_q        <= error_count_d;
            first_fail_index_q   <= first_fail_index_d;
            first_fail_command_q <= first_fail_command_d;
        end
    end

    assign alu_operandA       = operand_a_q;
    assign alu_operandB       = operand_b_q;
    assign alu_command        = command_q;
    assign busy               = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done               = (state_q == ST_DONE);
    assign pass               = (state_q == ST_DONE) && (error_count_q == 16'd0);
    assign error_count        = error_count_q;
    assign first_fail_index   = first_fail_index_q;
    assign first_fail_command = first_fail_command_q;

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// Bench for alu_bist_sequencer: four sequencers with different parameter sets, each beside a
// behavioural ALU (one with an optional stuck-at-0 on result bit 0), checked every cycle.
module tb_alu_bist_sequencer;

    localparam int NI = 4;
    localparam logic [NI-1:0][31:0] P_NV = {32'd4, 32'd1, 32'd1, 32'd1};
    localparam logic [NI-1:0][31:0] P_ST = {32'd1, 32'd2, 32'd2, 32'd2};
    localparam logic [NI-1:0][31:0] P_SA = {32'h0000_0004, 32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0004};
    localparam logic [NI-1:0][31:0] P_SB = {32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFE};
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        o;
        logic        z;
    } alu_out_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start [NI];
    logic        fault [NI];
    logic [31:0] opa [NI];
    logic [31:0] opb [NI];
    logic [2:0]  cmd [NI];
    logic [31:0] res [NI];
    logic        carry [NI];
    logic        zero [NI];
    logic        ovf [NI];
    logic        busy [NI];
    logic        done [NI];
    logic        pass [NI];
    logic [15:0] ecnt [NI];
    logic [18:0] ffi [NI];
    logic [2:0]  ffc [NI];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        model_ok = 1'b0;
    int          m_mode [NI];
    int          m_start [NI];
    logic [15:0] m_ecnt [NI];
    logic [18:0] m_ffi [NI];
    logic [2:0]  m_ffc [NI];
    logic        done_prev [NI];
    int          rise_cyc [NI];
    int          start_edge;

    always #5 clk = ~clk;

    // Reference ALU behaviour written from the arithmetic meaning of each command.
    function automatic alu_out_t golden(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        alu_out_t    g;
        logic [32:0] s;
        longint      wide;
        g = '0;
        case (c)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                g.r = s[31:0]; g.c = s[32];
                wide = longint'($signed(a)) + longint'($signed(b));
                g.o = (wide > SMAX) || (wide < SMIN);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                g.r = s[31:0]; g.c = s[32];
                wide = longint'($signed(a)) - longint'($signed(b));
                g.o = (wide > SMAX) || (wide < SMIN);
            end
            3'd2: g.r = a ^ b;
            3'd3: g.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: g.r = a & b;
            3'd5: g.r = ~(a & b);
            3'd6: g.r = ~(a | b);
            default: g.r = a | b;
        endcase
        g.z = (g.r == 32'd0);
        return g;
    endfunction

    function automatic alu_out_t bench_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] c, input logic f);
        alu_out_t g;
        g = golden(a, b, c);
        if (f) begin
            g.r[0] = 1'b0;
            g.z = (g.r == 32'd0);
        end
        return g;
    endfunction

    function automatic logic differs(input alu_out_t seen, input alu_out_t want, input logic [2:0] c);
        logic d;
        d = (seen.r != want.r) || (seen.z != want.z);
        if (c <= 3'd1) d = d || (seen.c != want.c) || (seen.o != want.o);
        return d;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [32:0] t;
        t = {s, 1'b0};
        if (t[32]) t = t ^ 33'h1_0040_0007;
        return t[31:0];
    endfunction

    function automatic logic [31:0] vec_op(input logic [31:0] seed, input int v);
        logic [31:0] s;
        s = (seed == 32'd0) ? 32'd1 : seed;
        for (int i = 0; i < v; i++) s = lfsr_next(s);
        return s;
    endfunction

    function automatic int total_cycles(input int g);
        return int'(P_NV[g]) * 8 * (int'(P_ST[g]) + 1);
    endfunction

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            alu_bist_sequencer #(
                .NUM_VECTORS   (int'(P_NV[g])),
                .SETTLE_CYCLES (int'(P_ST[g])),
                .SEED_A        (P_SA[g]),
                .SEED_B        (P_SB[g])
            ) u_dut (
                .clk                (clk),
                .reset              (reset),
                .start              (start[g]),
                .alu_operandA       (opa[g]),
                .alu_operandB       (opb[g]),
                .alu_command        (cmd[g]),
                .alu_result         (res[g]),
                .alu_carryout       (carry[g]),
                .alu_zero           (zero[g]),
                .alu_overflow       (ovf[g]),
                .busy               (busy[g]),
                .done               (done[g]),
                .pass               (pass[g]),
                .error_count        (ecnt[g]),
                .first_fail_index   (ffi[g]),
                .first_fail_command (ffc[g])
            );

            always_comb begin
                alu_out_t o;
                o = bench_alu(opa[g], opb[g], cmd[g], fault[g]);
                res[g]   = o.r;
                carry[g] = o.c;
                ovf[g]   = o.o;
                zero[g]  = o.z;
            end
        end
    endgenerate

    task automatic checkOutput(input string name, input int g, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s[%0d]: got %0h, expected %0h at cycle %0d", name, g, got, exp, cyc);
        end
    endtask

    task automatic predict(input int g, output logic [15:0] e, output logic [18:0] fi, output logic [2:0] fc);
        e = 16'd0; fi = 19'd0; fc = 3'd0;
        for (int k = 0; k < int'(P_NV[g]) * 8; k++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [2:0]  c;
            a = vec_op(P_SA[g], k / 8);
            b = vec_op(P_SB[g], k / 8);
            c = 3'(k % 8);
            if (differs(bench_alu(a, b, c, fault[g]), golden(a, b, c), c)) begin
                if (e == 16'd0) begin
                    fi = 19'(k);
                    fc = c;
                end
                if (e != 16'hFFFF) e = e + 16'd1;
            end
        end
    endtask

    // Run tracker: a start is taken only when the model says the sequencer is not mid-run.
    always @(posedge clk) begin
        logic [15:0] e;
        logic [18:0] fi;
        logic [2:0]  fc;
        cyc <= cyc + 1;
        if (reset) model_ok <= 1'b1;
        for (int g = 0; g < NI; g++) begin
            if (reset) begin
                m_mode[g] <= 0;
            end else if (start[g] && !(m_mode[g] == 1 && (cyc - m_start[g]) < total_cycles(g))) begin
                predict(g, e, fi, fc);
                m_mode[g]  <= 1;
                m_start[g] <= cyc + 1;
                m_ecnt[g]  <= e;
                m_ffi[g]   <= fi;
                m_ffc[g]   <= fc;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            for (int g = 0; g < NI; g++) begin
                int          el;
                int          tot;
                int          k;
                logic [31:0] ea, eb, ec, eb_busy, e_done, e_pass, e_cnt, e_fi, e_fc;
                ea = 0; eb = 0; ec = 0; eb_busy = 0; e_done = 0; e_pass = 0; e_cnt = 0; e_fi = 0; e_fc = 0;
                if (m_mode[g] == 1) begin
                    tot = total_cycles(g);
                    el  = cyc - m_start[g];
                    k   = (el < tot) ? el / (int'(P_ST[g]) + 1) : int'(P_NV[g]) * 8 - 1;
                    ea  = vec_op(P_SA[g], k / 8);
                    eb  = vec_op(P_SB[g], k / 8);
                    ec  = 32'(k % 8);
                    eb_busy = 32'(el < tot);
                    e_done  = 32'(el >= tot);
                    if (el >= tot) begin
                        e_pass = 32'(m_ecnt[g] == 16'd0);
                        e_cnt  = 32'(m_ecnt[g]);
                        e_fi   = 32'(m_ffi[g]);
                        e_fc   = 32'(m_ffc[g]);
                    end
                end
                checkOutput("operandA", g, opa[g], ea);
                checkOutput("operandB", g, opb[g], eb);
                checkOutput("command", g, 32'(cmd[g]), ec);
                checkOutput("busy", g, 32'(busy[g]), eb_busy);
                checkOutput("done", g, 32'(done[g]), e_done);
                if (e_done[0] || m_mode[g] == 0) begin
                    checkOutput("pass", g, 32'(pass[g]), e_pass);
                    checkOutput("error_count", g, 32'(ecnt[g]), e_cnt);
                    checkOutput("first_fail_index", g, 32'(ffi[g]), e_fi);
                    checkOutput("first_fail_command", g, 32'(ffc[g]), e_fc);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (done[g] === 1'b1 && done_prev[g] !== 1'b1) rise_cyc[g] <= cyc;
            done_prev[g] <= done[g];
        end
    end

    task automatic applyStimulus(input logic [NI-1:0] mask);
        @(negedge clk);
        for (int i = 0; i < NI; i++) start[i] = mask[i];
        @(negedge clk);
        for (int i = 0; i < NI; i++) start[i] = 1'b0;
    endtask

    task automatic waitDone(input int g, input int budget);
        int n;
        n = 0;
        while (done[g] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done[g] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_timeout[%0d]: got done=0, expected done within %0d cycles", g, budget);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0;
            fault[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        checkOutput("reset_operandA", 0, opa[0], 32'd0);
        checkOutput("reset_busy", 0, 32'(busy[0]), 32'd0);
        reset = 1'b0;

        $display("[TB] correct ALU on all four sequencers");
        applyStimulus(4'b1111);
        start_edge = cyc;
        checkOutput("add_a", 0, opa[0], 32'h0000_0004);
        checkOutput("add_b", 0, opb[0], 32'hFFFF_FFFE);
        checkOutput("add_result", 0, res[0], 32'd2);
        checkOutput("add_carry", 0, 32'(carry[0]), 32'd1);
        checkOutput("add_overflow", 0, 32'(ovf[0]), 32'd0);
        checkOutput("add_a", 1, opa[1], 32'h7FFF_FFFF);
        checkOutput("add_result", 1, res[1], 32'h8000_0000);
        checkOutput("add_overflow", 1, 32'(ovf[1]), 32'd1);
        checkOutput("add_carry", 1, 32'(carry[1]), 32'd0);
        checkOutput("zero_seed_a", 2, opa[2], 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("sub_command", 2, 32'(cmd[2]), 32'd1);
        checkOutput("sub_result", 2, res[2], 32'd0);
        checkOutput("sub_zero", 2, 32'(zero[2]), 32'd1);
        checkOutput("sub_carry", 2, 32'(carry[2]), 32'd1);
        repeat (6) @(negedge clk);
        checkOutput("slt_command", 1, 32'(cmd[1]), 32'd3);
        checkOutput("slt_result", 1, res[1], 32'd0);

        $display("[TB] start pulsed while busy");
        applyStimulus(4'b1001);
        waitDone(3, 200);
        checkOutput("run_length", 0, 32'(rise_cyc[0] - start_edge), 32'd24);
        checkOutput("run_length", 3, 32'(rise_cyc[3] - start_edge), 32'd64);
        for (int g = 0; g < NI; g++) begin
            checkOutput("final_pass", g, 32'(pass[g]), 32'd1);
            checkOutput("final_errors", g, 32'(ecnt[g]), 32'd0);
        end

        $display("[TB] result bit 0 stuck at 0");
        fault[0] = 1'b1;
        applyStimulus(4'b0001);
        start_edge = cyc;
        waitDone(0, 100);
        checkOutput("fault_errors", 0, 32'(ecnt[0]), 32'd2);
        checkOutput("fault_first_cmd", 0, 32'(ffc[0]), 32'd5);
        checkOutput("fault_first_index", 0, 32'(ffi[0]), 32'd5);
        checkOutput("fault_pass", 0, 32'(pass[0]), 32'd0);
        checkOutput("fault_run_length", 0, 32'(rise_cyc[0] - start_edge), 32'd24);
        fault[0] = 1'b0;

        $display("[TB] reset during SETTLE of check 3");
        applyStimulus(4'b0001);
        repeat (9) @(negedge clk);
        checkOutput("pre_reset_command", 0, 32'(cmd[0]), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_operandA", 0, opa[0], 32'd0);
        checkOutput("abort_busy", 0, 32'(busy[0]), 32'd0);
        checkOutput("abort_errors", 0, 32'(ecnt[0]), 32'd0);
        reset = 1'b0;
        applyStimulus(4'b0001);
        checkOutput("rerun_a", 0, opa[0], 32'h0000_0004);
        checkOutput("rerun_b", 0, opb[0], 32'hFFFF_FFFE);
        waitDone(0, 100);
        checkOutput("rerun_pass", 0, 32'(pass[0]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
